// File: rtl/miriscv_mult_seq.sv
// ---------------------------------------------------------------------------
// miriscv_mult_seq
//
// Multi-cycle shift-add multiplier that answers the MDU multiply handshake.
// The MDU raises req_i and holds it, stalling the pipeline, until rdy_o
// pulses. The MDU takes result_o in that same cycle. Operand signedness is
// selected per operand, so MUL, MULH, MULHSU and MULHU all use this block.
//
// Operation: both operands are reduced to unsigned magnitudes and the sign of
// the product is remembered. Each CALC cycle retires BITS_PER_CYCLE bits of
// the multiplier. The accumulated magnitude is negated on completion when
// the product sign is negative.
//
// Ports:
//   clk_i       : clock
//   arstn_i     : asynchronous reset, active low
//   req_i       : multiply request, held high until rdy_o
//   a_i, b_i    : operands (XLEN bits)
//   a_signed_i  : a_i is two's complement
//   b_signed_i  : b_i is two's complement
//   kill_i      : abort the operation in flight
//   result_o    : full 2*XLEN-bit product, registered
//   rdy_o       : one-cycle pulse, result_o valid
//   busy_o      : high while an operation is in CALC or DONE
// ---------------------------------------------------------------------------
module miriscv_mult_seq #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              req_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic              a_signed_i,
  input  logic              b_signed_i,
  input  logic              kill_i,
  output logic [2*XLEN-1:0] result_o,
  output logic              rdy_o,
  output logic              busy_o
);

  localparam int N      = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int PW     = XLEN + BITS_PER_CYCLE;  // width of one partial product
  localparam int PROD_W = 2 * XLEN;
  localparam int SHW    = $clog2(PROD_W);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  // Elaboration-time guard on the step size.
  if ((XLEN % BITS_PER_CYCLE) != 0 ||
      !(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
        BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_param
    $error("miriscv_mult_seq: BITS_PER_CYCLE must be 1, 2, 4 or 8 and divide XLEN");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  state_t              state_reg;
  logic [XLEN-1:0]     a_mag_reg;
  logic [XLEN-1:0]     b_mag_reg;
  logic                neg_reg;
  logic [PROD_W-1:0]   acc_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [PROD_W-1:0]   result_reg;

  // -------------------------------------------------------------------------
  // Operand conditioning at request time
  // -------------------------------------------------------------------------
  logic            a_neg_in;
  logic            b_neg_in;
  logic            neg_in;
  logic [XLEN-1:0] a_mag_in;
  logic [XLEN-1:0] b_mag_in;
  logic            zero_in;

  assign a_neg_in = a_signed_i & a_i[XLEN-1];
  assign b_neg_in = b_signed_i & b_i[XLEN-1];
  assign neg_in   = a_neg_in ^ b_neg_in;

  // The magnitude of the most negative value is 2^(XLEN-1). That value still
  // fits as an unsigned XLEN-bit number, so no overflow case needs handling.
  assign a_mag_in = a_neg_in ? ('0 - a_i) : a_i;
  assign b_mag_in = b_neg_in ? ('0 - b_i) : b_i;
  assign zero_in  = (a_i == '0) || (b_i == '0);

  // -------------------------------------------------------------------------
  // One step's partial product: a_mag * b_mag[BITS_PER_CYCLE-1:0]
  // -------------------------------------------------------------------------
  logic [PW-1:0] pp_term [BITS_PER_CYCLE];
  logic [PW-1:0] partial;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
    assign pp_term[gi] = b_mag_reg[gi] ? (PW'(a_mag_reg) << gi) : '0;
  end

  always_comb begin
    partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      partial = partial + pp_term[i];
    end
  end

  // The step weight is cnt*BITS_PER_CYCLE. Its largest value,
  // (N-1)*BITS_PER_CYCLE, is always below 2*XLEN.
  logic [SHW-1:0]    shamt;
  logic [PROD_W-1:0] partial_shifted;
  logic [PROD_W-1:0] acc_sum;
  logic [PROD_W-1:0] acc_neg;

  assign shamt           = SHW'(cnt_reg) * SHW'(BITS_PER_CYCLE);
  assign partial_shifted = PROD_W'(partial) << shamt;
  assign acc_sum         = acc_reg + partial_shifted;
  assign acc_neg         = '0 - acc_sum;

  // -------------------------------------------------------------------------
  // Control and datapath state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_reg  <= ST_IDLE;
      a_mag_reg  <= '0;
      b_mag_reg  <= '0;
      neg_reg    <= 1'b0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // kill_i takes priority over a new request.
          if (req_i && !kill_i) begin
            if (zero_in) begin
              // A zero operand gives a known product, so skip the iteration.
              result_reg <= '0;
              state_reg  <= ST_DONE;
            end else begin
              a_mag_reg <= a_mag_in;
              b_mag_reg <= b_mag_in;
              neg_reg   <= neg_in;
              acc_reg   <= '0;
              cnt_reg   <= '0;
              state_reg <= ST_CALC;
            end
          end
        end

        ST_CALC: begin
          // Dropping req_i mid-operation is treated exactly like a kill.
          // result_o is left untouched in both cases.
          if (kill_i || !req_i) begin
            state_reg <= ST_IDLE;
          end else begin
            acc_reg   <= acc_sum;
            b_mag_reg <= b_mag_reg >> BITS_PER_CYCLE;
            cnt_reg   <= cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_LAST) begin
              result_reg <= neg_reg ? acc_neg : acc_sum;
              state_reg  <= ST_DONE;
            end
          end
        end

        // The result is already committed here. rdy_o pulses even if
        // kill_i arrives in this cycle.
        ST_DONE: state_reg <= ST_IDLE;

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign result_o = result_reg;
  assign rdy_o    = (state_reg == ST_DONE);
  assign busy_o   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_miriscv_mult_seq.sv
module tb_miriscv_mult_seq;

  localparam int XLEN    = 32;
  localparam int N       = 8;
  localparam int TIMEOUT = 40;

  logic              clk_i = 1'b0;
  logic              arstn_i;
  logic              req_i;
  logic [XLEN-1:0]   a_i;
  logic [XLEN-1:0]   b_i;
  logic              a_signed_i;
  logic              b_signed_i;
  logic              kill_i;
  logic [2*XLEN-1:0] result_o;
  logic              rdy_o;
  logic              busy_o;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q [$];
  logic [63:0] last_result;

  miriscv_mult_seq #(.XLEN(XLEN), .BITS_PER_CYCLE(4)) dut (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .req_i      (req_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .a_signed_i (a_signed_i),
    .b_signed_i (b_signed_i),
    .kill_i     (kill_i),
    .result_o   (result_o),
    .rdy_o      (rdy_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference product: extend each operand by its signedness, then multiply wide.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic as, input logic bs);
    logic signed [65:0] ea;
    logic signed [65:0] eb;
    logic signed [65:0] p;
    ea = as ? {{34{a[31]}}, a} : {34'b0, a};
    eb = bs ? {{34{b[31]}}, b} : {34'b0, b};
    p  = ea * eb;
    return p[63:0];
  endfunction

  // Issue one request and wait for rdy_o, within a cycle budget. After the
  // request is sampled, the operands are scrambled to show that they were
  // latched. The task returns at the negedge after the DONE cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic as, input logic bs,
                        output int lat, output logic [63:0] res, output int busy_low);
    exp_q.push_back(model(a, b, as, bs));
    a_i = a; b_i = b; a_signed_i = as; b_signed_i = bs;
    kill_i = 1'b0; req_i = 1'b1;
    lat = 0; busy_low = 0;
    while (lat < TIMEOUT) begin
      @(posedge clk_i);
      lat++;
      #1;
      a_i = $urandom; b_i = $urandom;
      a_signed_i = 1'($urandom_range(0, 1));
      b_signed_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      if (!busy_o) busy_low++;
      if (rdy_o) break;
    end
    res = result_o;
    req_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    arstn_i = 1'b0; req_i = 1'b0; kill_i = 1'b0;
    a_i = '0; b_i = '0; a_signed_i = 1'b0; b_signed_i = 1'b0;
    #12;
    checks++; if (result_o !== 64'd0) begin failures++; $display("FAIL reset_result: got %h expected %h", result_o, 64'd0); end
    checks++; if (rdy_o !== 1'b0) begin failures++; $display("FAIL reset_rdy: got %b expected 0", rdy_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    @(negedge clk_i);
    arstn_i = 1'b1;
    @(negedge clk_i);
    last_result = 64'd0;
  endtask

  task automatic test_unsigned_max();
    int lat; int bl; logic [63:0] res; logic [63:0] exp;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, res, bl);
    exp = exp_q.pop_front();
    checks++; if (res !== exp) begin failures++; $display("FAIL umax_result: got %h expected %h", res, exp); end
    checks++; if (lat !== N + 1) begin failures++; $display("FAIL umax_latency: got %0d expected %0d", lat, N + 1); end
    checks++; if (bl !== 0) begin failures++; $display("FAIL umax_busy: low in %0d cycles expected 0", bl); end
    checks++; if (rdy_o !== 1'b0) begin failures++; $display("FAIL umax_rdy_pulse: got %b expected 0", rdy_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL umax_idle_busy: got %b expected 0", busy_o); end
    $display("op umax %h lat=%0d", res, lat);
    last_result = exp;
  endtask

  task automatic test_signed_corners();
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    int lat; int bl; logic [63:0] res; logic [63:0] exp;
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'hFFFF_FFFF;
    ta[1] = 32'h8000_0000; tb[1] = 32'h8000_0000;
    ta[2] = 32'h8000_0000; tb[2] = 32'h0000_0001;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], 1'b1, 1'b1, lat, res, bl);
      exp = exp_q.pop_front();
      checks++; if (res !== exp) begin failures++; $display("FAIL signed_%0d_result: got %h expected %h", i, res, exp); end
      checks++; if (lat !== N + 1) begin failures++; $display("FAIL signed_%0d_latency: got %0d expected %0d", i, lat, N + 1); end
      checks++; if (bl !== 0) begin failures++; $display("FAIL signed_%0d_busy: low in %0d cycles expected 0", i, bl); end
      $display("op signed %h x %h = %h lat=%0d", ta[i], tb[i], res, lat);
      last_result = exp;
    end
  endtask

  task automatic test_mixed_sign();
    int lat; int bl; logic [63:0] res; logic [63:0] exp;
    for (int i = 0; i < 2; i++) begin
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, (i == 0), (i == 1), lat, res, bl);
      exp = exp_q.pop_front();
      checks++; if (res !== exp) begin failures++; $display("FAIL mixed_%0d_result: got %h expected %h", i, res, exp); end
      checks++; if (lat !== N + 1) begin failures++; $display("FAIL mixed_%0d_latency: got %0d expected %0d", i, lat, N + 1); end
      checks++; if (bl !== 0) begin failures++; $display("FAIL mixed_%0d_busy: low in %0d cycles expected 0", i, bl); end
      $display("op mixed_%0d %h lat=%0d", i, res, lat);
      last_result = exp;
    end
  endtask

  task automatic test_zero_shortcut();
    int lat; int bl; logic [63:0] res; logic [63:0] exp;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) run_op(32'h1234_5678, 32'h0, 1'b0, 1'b0, lat, res, bl);
      else        run_op(32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1, lat, res, bl);
      exp = exp_q.pop_front();
      checks++; if (res !== exp) begin failures++; $display("FAIL zero_%0d_result: got %h expected %h", i, res, exp); end
      checks++; if (lat !== 1) begin failures++; $display("FAIL zero_%0d_latency: got %0d expected 1", i, lat); end
      checks++; if (bl !== 0) begin failures++; $display("FAIL zero_%0d_busy: low in %0d cycles expected 0", i, bl); end
      $display("op zero_%0d %h lat=%0d", i, res, lat);
      last_result = exp;
    end
  endtask

  // use_abort=0: kill_i with req_i held; use_abort=1: req_i dropped instead.
  task automatic test_kill(input bit use_abort);
    int lat; int bl; logic [63:0] res; logic [63:0] exp;
    a_i = 32'd7; b_i = 32'd6; a_signed_i = 1'b0; b_signed_i = 1'b0;
    kill_i = 1'b0; req_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    if (use_abort) req_i = 1'b0;
    else           kill_i = 1'b1;
    @(posedge clk_i);
    #1;
    kill_i = 1'b0; req_i = 1'b0;
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL kill%0d_busy: got %b expected 0", use_abort, busy_o); end
    checks++; if (rdy_o !== 1'b0) begin failures++; $display("FAIL kill%0d_rdy: got %b expected 0", use_abort, rdy_o); end
    checks++; if (result_o !== last_result) begin failures++; $display("FAIL kill%0d_hold: got %h expected %h", use_abort, result_o, last_result); end
    $display("op kill%0d aborted result_o=%h", use_abort, result_o);
    run_op(32'd3, 32'd5, 1'b0, 1'b0, lat, res, bl);
    exp = exp_q.pop_front();
    checks++; if (res !== exp) begin failures++; $display("FAIL kill%0d_next_result: got %h expected %h", use_abort, res, exp); end
    checks++; if (lat !== N + 1) begin failures++; $display("FAIL kill%0d_next_latency: got %0d expected %0d", use_abort, lat, N + 1); end
    checks++; if (bl !== 0) begin failures++; $display("FAIL kill%0d_next_busy: low in %0d cycles expected 0", use_abort, bl); end
    $display("op kill%0d_next %h lat=%0d", use_abort, res, lat);
    last_result = exp;
  endtask

  task automatic test_back_to_back();
    int lat; logic [63:0] exp;
    a_i = 32'd2; b_i = 32'd3; a_signed_i = 1'b0; b_signed_i = 1'b0;
    kill_i = 1'b0; req_i = 1'b1;
    exp_q.push_back(model(32'd2, 32'd3, 1'b0, 1'b0));
    lat = 0;
    while (lat < TIMEOUT) begin
      @(posedge clk_i); lat++;
      @(negedge clk_i);
      if (rdy_o) break;
    end
    exp = exp_q.pop_front();
    checks++; if (result_o !== exp) begin failures++; $display("FAIL b2b_first_result: got %h expected %h", result_o, exp); end
    checks++; if (lat !== N + 1) begin failures++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, N + 1); end
    $display("op b2b_first %h lat=%0d", result_o, lat);
    // req_i stays high; the next operands are sampled in the following IDLE cycle.
    a_i = 32'd4; b_i = 32'd5;
    exp_q.push_back(model(32'd4, 32'd5, 1'b0, 1'b0));
    lat = 0;
    while (lat < TIMEOUT) begin
      @(posedge clk_i); lat++;
      @(negedge clk_i);
      if (rdy_o) break;
    end
    exp = exp_q.pop_front();
    checks++; if (result_o !== exp) begin failures++; $display("FAIL b2b_second_result: got %h expected %h", result_o, exp); end
    checks++; if (lat !== N + 2) begin failures++; $display("FAIL b2b_second_gap: got %0d expected %0d", lat, N + 2); end
    $display("op b2b_second %h gap=%0d", result_o, lat);
    last_result = exp;
    req_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_reset_midop();
    int rdy_seen;
    a_i = 32'h0000_1234; b_i = 32'h0000_5678; a_signed_i = 1'b0; b_signed_i = 1'b0;
    kill_i = 1'b0; req_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1 arstn_i = 1'b0;
    #1;
    checks++; if (result_o !== 64'd0) begin failures++; $display("FAIL midrst_result: got %h expected %h", result_o, 64'd0); end
    checks++; if (rdy_o !== 1'b0) begin failures++; $display("FAIL midrst_rdy: got %b expected 0", rdy_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy_o); end
    @(negedge clk_i);
    req_i = 1'b0;
    @(posedge clk_i);
    #1 arstn_i = 1'b1;
    rdy_seen = 0;
    repeat (15) begin
      @(negedge clk_i);
      if (rdy_o) rdy_seen++;
    end
    checks++; if (rdy_seen !== 0) begin failures++; $display("FAIL midrst_no_rdy: got %0d pulses expected 0", rdy_seen); end
    checks++; if (result_o !== 64'd0) begin failures++; $display("FAIL midrst_hold: got %h expected %h", result_o, 64'd0); end
    $display("op midrst rdy_pulses=%0d result_o=%h", rdy_seen, result_o);
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_corners();
    test_mixed_sign();
    test_zero_shortcut();
    test_kill(1'b0);
    test_kill(1'b1);
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
